// File: rtl/parking_gate_arbiter_if.sv
// Gate arbiter handshake bundle: sensor/authorisation requests in,
// barrier control and occupancy status out.
interface parking_gate_arbiter_if;
    logic       entry_req;
    logic       exit_req;
    logic       auth_ok;
    logic       auth_fail;
    logic       vehicle_clear;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic       deny;
    logic       timeout;
    logic       full;
    logic [4:0] count;

    // Controller/environment side: drives requests, observes gate status.
    modport master (
        output entry_req, exit_req, auth_ok, auth_fail, vehicle_clear,
        input  gate_open, entry_grant, exit_grant, deny, timeout, full, count
    );

    // Arbiter side.
    modport slave (
        input  entry_req, exit_req, auth_ok, auth_fail, vehicle_clear,
        output gate_open, entry_grant, exit_grant, deny, timeout, full, count
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared-barrier arbiter for a car park: round-robin between the entry and
// exit lanes, password authorisation for entries, gate-open watchdog and a
// saturating occupancy counter. All outputs are registered.
//
//   state | meaning
//   IDLE  | no owner; requests sampled here only
//   AUTH  | entry owns gate, waiting for auth_ok/auth_fail (AUTH_CYCLES max)
//   OPEN  | barrier up, waiting for vehicle_clear (OPEN_CYCLES max)
//   CLOSE | barrier down for one cycle; occupancy updated on exit from here
module parking_gate_arbiter #(
    parameter int CAPACITY    = 20,   // legal range 1..31
    parameter int AUTH_CYCLES = 8,
    parameter int OPEN_CYCLES = 16
) (
    input logic                  clk,
    input logic                  reset,
    parking_gate_arbiter_if.slave bus
);
    localparam int TMAX = (AUTH_CYCLES > OPEN_CYCLES) ? AUTH_CYCLES : OPEN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] AUTH_LOAD = TW'(AUTH_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [4:0]    CAP       = 5'(CAPACITY);

    typedef enum logic [1:0] {IDLE = 2'd0, AUTH = 2'd1, OPEN = 2'd2, CLOSE = 2'd3} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          last_exit;     // last served lane: 0 = entry, 1 = exit
    logic          complete;      // vehicle passed during OPEN
    logic          gate_open_q;
    logic          entry_grant_q;
    logic          exit_grant_q;
    logic          deny_q;
    logic          timeout_q;
    logic          full_q;
    logic [4:0]    count_q;
    logic [4:0]    count_next;
    logic          entry_ok;
    logic          pick_exit;
    logic          pick_entry;

    // Lane selection in IDLE: exit is always eligible, entry only when not
    // full; on a tie the lane not served last wins.
    always_comb begin
        entry_ok   = bus.entry_req && !full_q;
        pick_exit  = bus.exit_req && (!entry_ok || !last_exit);
        pick_entry = entry_ok && !pick_exit;
    end

    // Occupancy after a finished transaction, saturating at 0 and CAPACITY.
    always_comb begin
        count_next = count_q;
        if (complete && entry_grant_q && (count_q < CAP))
            count_next = count_q + 5'd1;
        else if (complete && exit_grant_q && (count_q != 5'd0))
            count_next = count_q - 5'd1;
    end

    // Arbiter FSM with registered outputs; timers are down-counters loaded on state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            last_exit     <= 1'b0;
            complete      <= 1'b0;
            gate_open_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            deny_q        <= 1'b0;
            timeout_q     <= 1'b0;
            full_q        <= 1'b0;
            count_q       <= 5'd0;
        end else begin
            deny_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_exit) begin
                        state        <= OPEN;
                        exit_grant_q <= 1'b1;
                        gate_open_q  <= 1'b1;
                        timer        <= OPEN_LOAD;
                        complete     <= 1'b0;
                    end else if (pick_entry) begin
                        state         <= AUTH;
                        entry_grant_q <= 1'b1;
                        timer         <= AUTH_LOAD;
                    end
                end
                AUTH: begin
                    if (bus.auth_fail || (!bus.auth_ok && timer == '0)) begin
                        state         <= IDLE;
                        entry_grant_q <= 1'b0;
                        deny_q        <= 1'b1;
                        last_exit     <= 1'b0;
                        timer         <= '0;
                    end else if (bus.auth_ok) begin
                        state       <= OPEN;
                        gate_open_q <= 1'b1;
                        timer       <= OPEN_LOAD;
                        complete    <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                OPEN: begin
                    if (bus.vehicle_clear) begin
                        state       <= CLOSE;
                        gate_open_q <= 1'b0;
                        complete    <= 1'b1;
                        timer       <= '0;
                    end else if (timer == '0) begin
                        state       <= CLOSE;
                        gate_open_q <= 1'b0;
                        complete    <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CLOSE: begin
                    state         <= IDLE;
                    last_exit     <= exit_grant_q;
                    entry_grant_q <= 1'b0;
                    exit_grant_q  <= 1'b0;
                    count_q       <= count_next;
                    full_q        <= (count_next == CAP);
                    complete      <= 1'b0;
                    timer         <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate_open   = gate_open_q;
    assign bus.entry_grant = entry_grant_q;
    assign bus.exit_grant  = exit_grant_q;
    assign bus.deny        = deny_q;
    assign bus.timeout     = timeout_q;
    assign bus.full        = full_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model of the car park.
module tb_parking_gate_arbiter;
    localparam int CAP  = 20;
    localparam int AUTH = 8;
    localparam int OPEN = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   chk_en;

    parking_gate_arbiter_if bus ();

    parking_gate_arbiter #(
        .CAPACITY    (CAP),
        .AUTH_CYCLES (AUTH),
        .OPEN_CYCLES (OPEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the gate, what the transaction is doing, and how long.
    int m_owner;      // 0 none, 1 entry, 2 exit
    bit m_auth, m_open, m_close, m_done, m_last_exit, m_deny, m_to;
    int m_age, m_count;
    bit e_ok;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = 0; m_auth = 0; m_open = 0; m_close = 0; m_done = 0;
            m_age = 0; m_count = 0; m_last_exit = 0; m_deny = 0; m_to = 0;
        end else begin
            m_deny = 0;
            m_to   = 0;
            if (m_close) begin
                if (m_done && m_owner == 1 && m_count < CAP) m_count = m_count + 1;
                if (m_done && m_owner == 2 && m_count > 0)   m_count = m_count - 1;
                m_last_exit = (m_owner == 2);
                m_owner = 0;
                m_close = 0;
            end else if (m_owner == 0) begin
                e_ok = bus.entry_req && (m_count != CAP);
                if (bus.exit_req && (!e_ok || !m_last_exit)) begin
                    m_owner = 2; m_open = 1; m_age = 0;
                end else if (e_ok) begin
                    m_owner = 1; m_auth = 1; m_age = 0;
                end
            end else if (m_auth) begin
                m_age = m_age + 1;
                if (bus.auth_fail || (!bus.auth_ok && m_age == AUTH)) begin
                    m_deny = 1; m_owner = 0; m_auth = 0; m_last_exit = 0;
                end else if (bus.auth_ok) begin
                    m_auth = 0; m_open = 1; m_age = 0;
                end
            end else if (m_open) begin
                m_age = m_age + 1;
                if (bus.vehicle_clear) begin
                    m_open = 0; m_close = 1; m_done = 1;
                end else if (m_age == OPEN) begin
                    m_open = 0; m_close = 1; m_done = 0; m_to = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("gate_open",   32'(bus.gate_open),   32'(m_open));
            check("entry_grant", 32'(bus.entry_grant), 32'(m_owner == 1));
            check("exit_grant",  32'(bus.exit_grant),  32'(m_owner == 2));
            check("deny",        32'(bus.deny),        32'(m_deny));
            check("timeout",     32'(bus.timeout),     32'(m_to));
            check("full",        32'(bus.full),        32'(m_count == CAP));
            check("count",       32'(bus.count),       32'(m_count));
        end
    end

    // Event tallies over the cycle that just ended.
    int gate_cycles, deny_cnt, to_cnt;
    always @(posedge clk) begin
        if (bus.gate_open) gate_cycles++;
        if (bus.deny)      deny_cnt++;
        if (bus.timeout)   to_cnt++;
    end

    // Drive one cycle of inputs, then return just after the next falling edge.
    task automatic step(input bit e, input bit x, input bit ok, input bit fl, input bit cl);
        bus.entry_req     = e;
        bus.exit_req      = x;
        bus.auth_ok       = ok;
        bus.auth_fail     = fl;
        bus.vehicle_clear = cl;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic park_one();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int r;
        checks = 0; errors = 0; chk_en = 0;
        reset = 1'b1;
        bus.entry_req = 0; bus.exit_req = 0; bus.auth_ok = 0;
        bus.auth_fail = 0; bus.vehicle_clear = 0;
        @(negedge clk); #1;
        do_reset();
        chk_en = 1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_gate",  32'(bus.gate_open), 0);
        check("rst_grants", 32'({bus.entry_grant, bus.exit_grant, bus.full}), 0);

        // Normal entry: auth_ok two cycles after the request, clear in 3rd OPEN cycle.
        gate_cycles = 0; deny_cnt = 0; to_cnt = 0;
        step(1, 0, 0, 0, 0);
        check("entry_auth_grant", 32'(bus.entry_grant), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("close_grant_held", 32'(bus.entry_grant), 1);
        step(0, 0, 0, 0, 0);
        check("entry_gate_cycles", 32'(gate_cycles), 3);
        check("entry_count", 32'(bus.count), 1);
        check("entry_no_deny_to", 32'(deny_cnt + to_cnt), 0);

        // Tie after an entry: exit first, then entry.
        step(1, 1, 0, 0, 0);
        check("tie_exit_first", 32'(bus.exit_grant), 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        check("tie_exit_count", 32'(bus.count), 0);
        step(1, 1, 0, 0, 0);
        check("tie_entry_next", 32'(bus.entry_grant), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("tie_entry_count", 32'(bus.count), 1);

        // Simultaneous ok and fail: fail wins.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("fail_deny", 32'(bus.deny), 1);
        check("fail_count", 32'(bus.count), 1);
        step(0, 0, 0, 0, 0);
        check("fail_deny_one_cycle", 32'(bus.deny), 0);

        // Authorisation timeout.
        step(1, 0, 0, 0, 0);
        repeat (AUTH - 1) step(0, 0, 0, 0, 0);
        check("auth_wait_no_deny", 32'({bus.entry_grant, bus.deny}), 32'b10);
        step(0, 0, 0, 0, 0);
        check("auth_timeout_deny", 32'({bus.entry_grant, bus.deny}), 32'b01);

        // Open timeout leaves count unchanged.
        step(1, 0, 0, 0, 0);
        gate_cycles = 0;
        step(0, 0, 1, 0, 0);
        repeat (OPEN) step(0, 0, 0, 0, 0);
        check("open_timeout_pulse", 32'(bus.timeout), 1);
        check("open_timeout_cycles", 32'(gate_cycles), 16);
        step(0, 0, 0, 0, 0);
        check("open_timeout_count", 32'(bus.count), 1);

        // Exits down to zero, then one more exit at zero.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("exit_to_zero", 32'(bus.count), 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("exit_at_zero", 32'(bus.count), 0);

        // Fill to capacity, then the full-lot behaviour.
        repeat (CAP) park_one();
        check("full_count", 32'(bus.count), 20);
        check("full_flag", 32'(bus.full), 1);
        deny_cnt = 0;
        repeat (3) step(1, 0, 0, 0, 0);
        check("full_no_grant", 32'({bus.entry_grant, deny_cnt[0]}), 0);
        step(1, 1, 0, 0, 0);
        check("full_exit_grant", 32'(bus.exit_grant), 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("full_after_exit", 32'({bus.full, bus.count}), 19);
        step(1, 0, 0, 0, 0);
        check("full_pending_entry", 32'(bus.entry_grant), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("refull_count", 32'({bus.full, bus.count}), 32'h34);

        // Reset mid-OPEN with five vehicles parked.
        do_reset();
        repeat (5) park_one();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("pre_reset_state", 32'({bus.gate_open, bus.count}), 32'h25);
        #1 reset = 1'b1;
        #1;
        check("async_reset_gate", 32'(bus.gate_open), 0);
        check("async_reset_count", 32'(bus.count), 0);
        check("async_reset_grant", 32'(bus.entry_grant), 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 399);
            if (r == 0) begin
                reset = 1'b1;
                step(0, 0, 0, 0, 0);
                reset = 1'b0;
            end else begin
                step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < 20);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
